// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch for the bbtron datapath.
//
// Holds the PC, fetches one word at a time from instruction memory over a
// req/ack handshake, presents it to decode and resolves jump/branch targets.
// Every output is registered.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   -> a watchdog counts FETCH cycles without imemAck. After
//                TIMEOUT_CYCLES of them, fetchError and halted are set and
//                the stage parks in HALT until reset.
//   undefined -> no counter is built, fetchError is tied 0, and FETCH waits
//                for the ack with no limit.
//
// Ports
//   clock, reset              : clock, async active-high reset
//   stall                     : decode cannot take the presented instruction
//   halt, jumpEn, branchEn    : consume-time controls from decode
//   jumpOffset, branchOffset  : sign-extended word offsets
//   imemReq, imemAddr         : fetch request, word address (== pc)
//   imemAck, imemData         : memory response
//   instrOut, instrPC         : presented instruction and its word address
//   instrValid                : instrOut/instrPC valid
//   halted, fetchError        : stopped by HALT or watchdog, watchdog fired
module fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        jumpEn,
  input  logic [31:0] jumpOffset,
  input  logic        branchEn,
  input  logic [31:0] branchOffset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instrOut,
  output logic [31:0] instrPC,
  output logic        instrValid,
  output logic        halted,
  output logic        fetchError
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] pc;

  // The request address is the PC register itself, so it is registered.
  assign imemAddr = pc;

`ifdef FETCH_TIMEOUT_EN
  // The counter only has to reach TIMEOUT_CYCLES-1; the next miss fires.
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdog;
  logic            wd_expire;
  assign wd_expire = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign fetchError = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imemReq    <= 1'b0;
      instrOut   <= '0;
      instrPC    <= '0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog       <= '0;
      fetchError <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          imemReq <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wdog    <= '0;
`endif
        end

        FETCH: begin
          if (imemAck) begin
            instrOut   <= imemData;
            instrPC    <= pc;
            pc         <= pc + 32'd1;
            instrValid <= 1'b1;
            imemReq    <= 1'b0;
            state      <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wd_expire) begin
            fetchError <= 1'b1;
            halted     <= 1'b1;
            imemReq    <= 1'b0;
            state      <= HALT;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end

        HOLD: begin
          // Consume happens only when decode is not stalling; a stall
          // freezes the presented instruction and the PC.
          if (!stall) begin
            instrValid <= 1'b0;
            if (halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state   <= FETCH;
              imemReq <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              wdog    <= '0;
`endif
              // pc already holds instrPC+1, which is the sequential target.
              if (jumpEn)
                pc <= instrPC + jumpOffset;
              else if (branchEn)
                pc <= instrPC + 32'd1 + branchOffset;
            end
          end
        end

        HALT: ;  // terminal until reset

        default: state <= IDLE;
      endcase
    end
  end

endmodule
